pic_control_logic: RTL

PIC_CONTROL_LOGIC -- requirements
Module: pic_control_logic

---
 rtl/pic_pkg.sv | 46 ++++
 rtl/pic_inta_sequencer.sv | 70 +++++++
 rtl/pic_control_logic.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC control block: init-state enum,
// OCW2 opcodes, and ICW/OCW bit positions.
package pic_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned VB_W   = 5;
  localparam int unsigned VEC_W  = 3;

  typedef enum logic [2:0] {
    WAIT_ICW1 = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } init_state_e;

  // OCW2 command codes carried in d[7:5]
  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  localparam int unsigned ICW1_IC4_BIT  = 0;
  localparam int unsigned ICW1_SNGL_BIT = 1;
  localparam int unsigned ICW1_LTIM_BIT = 3;
  localparam int unsigned ICW1_SEL_BIT  = 4;
  localparam int unsigned ICW4_AEOI_BIT = 1;
  localparam int unsigned OCW3_RIS_BIT  = 0;
  localparam int unsigned OCW3_RR_BIT   = 1;
  localparam int unsigned OCW3_P_BIT    = 2;

  localparam logic [1:0] OCW_SEL_OCW2 = 2'b00;
  localparam logic [1:0] OCW_SEL_OCW3 = 2'b01;

  function automatic logic [DATA_W-1:0] make_vector(
    input logic [VB_W-1:0]  base,
    input logic [VEC_W-1:0] vec
  );
    return {base, vec};
  endfunction

endpackage

// File: rtl/pic_inta_sequencer.sv
// INTA handshake: falling-edge detect, two-pulse counter, vector drive, and
// the shared data_out/data_oe register where the vector overrides read data.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_clr_count,
  input  logic              i_inta_n,
  input  logic [VEC_W-1:0]  i_int_vec,
  input  logic [VB_W-1:0]   i_vector_base,
  input  logic              i_rd_req,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_poll_ack,
  output logic              o_ack_first,
  output logic              o_ack_second,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_data_oe
);

  logic              r_inta_d;
  logic              r_count;
  logic              r_vec_oe;
  logic              r_ack_first;
  logic              r_ack_second;
  logic              r_data_oe;
  logic [DATA_W-1:0] r_data_out;

  logic w_fall;
  logic w_second;
  logic w_vec_drive;

  assign w_fall      = r_inta_d & ~i_inta_n & i_enable;
  assign w_second    = w_fall & r_count;
  // vector stays on the bus for as long as INTA remains low after the second edge
  assign w_vec_drive = w_second | (r_vec_oe & ~i_inta_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inta_d     <= 1'b1;
      r_count      <= 1'b0;
      r_vec_oe     <= 1'b0;
      r_ack_first  <= 1'b0;
      r_ack_second <= 1'b0;
      r_data_oe    <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_inta_d     <= i_inta_n;
      r_ack_first  <= (w_fall & ~r_count) | i_poll_ack;
      r_ack_second <= w_second;
      if (i_clr_count)
        r_count <= 1'b0;
      else if (w_fall)
        r_count <= ~r_count;
      r_vec_oe  <= w_vec_drive;
      r_data_oe <= w_vec_drive | i_rd_req;
      if (w_second)
        r_data_out <= make_vector(i_vector_base, i_int_vec);
      else if (!w_vec_drive)
        r_data_out <= i_rd_req ? i_rd_data : DATA_W'(0);
    end
  end

  assign o_ack_first  = r_ack_first;
  assign o_ack_second = r_ack_second;
  assign o_data_out   = r_data_out;
  assign o_data_oe    = r_data_oe;

endmodule

// File: rtl/pic_control_logic.sv
// PIC control logic: ICW init sequence, OCW decode, register reads, INTA
// vector delivery. Optional poll command enabled by macro PIC_POLL_EN.
module pic_control_logic
  import pic_pkg::*;
#(
  parameter logic [4:0] VEC_BASE_RST = 5'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        a0,
  input  logic [7:0]  data_in,
  input  logic        inta_n,
  input  logic        int_req,
  input  logic [2:0]  int_vec,
  input  logic [7:0]  irr,
  input  logic [7:0]  isr,
  input  logic [7:0]  imr,
  output logic [7:0]  IM,
  output logic [7:0]  operation,
  output logic        op_valid,
  output logic        LTIM,
  output logic        AEOI,
  output logic        ack_first,
  output logic        ack_second,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        ready
);

  init_state_e r_state;
  init_state_e w_state_nxt;

  logic              r_sngl;
  logic              r_ic4;
  logic              r_ltim;
  logic              r_aeoi;
  logic              r_read_sel;
  logic              r_op_valid;
  logic [DATA_W-1:0] r_im;
  logic [DATA_W-1:0] r_operation;
  logic [VB_W-1:0]   r_vector_base;

  logic              w_ready;
  logic              w_icw1;
  logic              w_data_wr;
  logic              w_ocw2;
  logic              w_ocw3;
  logic              w_poll_ack;
  logic [DATA_W-1:0] w_reg_rd;
  logic [DATA_W-1:0] w_rd_data;

  assign w_ready   = (r_state == READY);
  assign w_icw1    = wr_en & ~a0 & data_in[ICW1_SEL_BIT];
  assign w_data_wr = wr_en & a0;
  assign w_ocw2    = wr_en & ~a0 & w_ready & (data_in[4:3] == OCW_SEL_OCW2);
  assign w_ocw3    = wr_en & ~a0 & w_ready & (data_in[4:3] == OCW_SEL_OCW3);
  assign w_reg_rd  = a0 ? imr : (r_read_sel ? isr : irr);

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_ICW1;
    else     r_state <= w_state_nxt;
  end

  // ICW1 restarts the sequence from any state; later ICWs arrive on a0=1
  always_comb begin
    w_state_nxt = r_state;
    if (w_icw1) begin
      w_state_nxt = WAIT_ICW2;
    end else if (w_data_wr) begin
      case (r_state)
        WAIT_ICW2: w_state_nxt = !r_sngl ? WAIT_ICW3 : (r_ic4 ? WAIT_ICW4 : READY);
        WAIT_ICW3: w_state_nxt = r_ic4 ? WAIT_ICW4 : READY;
        WAIT_ICW4: w_state_nxt = READY;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sngl        <= 1'b0;
      r_ic4         <= 1'b0;
      r_ltim        <= 1'b0;
      r_aeoi        <= 1'b0;
      r_read_sel    <= 1'b0;
      r_op_valid    <= 1'b0;
      r_im          <= '0;
      r_operation   <= '0;
      r_vector_base <= VEC_BASE_RST;
    end else begin
      r_op_valid <= w_ocw2;
      if (w_icw1) begin
        r_ltim <= data_in[ICW1_LTIM_BIT];
        r_sngl <= data_in[ICW1_SNGL_BIT];
        r_ic4  <= data_in[ICW1_IC4_BIT];
        r_im   <= '0;
        r_aeoi <= 1'b0;
      end else if (w_data_wr) begin
        case (r_state)
          WAIT_ICW2: r_vector_base <= data_in[7:3];
          WAIT_ICW4: r_aeoi        <= data_in[ICW4_AEOI_BIT];
          READY:     r_im          <= data_in;
          default:   ;
        endcase
      end
      if (w_ocw2)
        r_operation <= data_in;
      if (w_ocw3 && data_in[OCW3_RR_BIT])
        r_read_sel <= data_in[OCW3_RIS_BIT];
    end
  end

`ifdef PIC_POLL_EN
  logic r_poll;

  always_ff @(posedge clk) begin
    if (rst)
      r_poll <= 1'b0;
    else if (w_ocw3 && data_in[OCW3_P_BIT])
      r_poll <= 1'b1;
    else if (rd_en)
      r_poll <= 1'b0;
  end

  assign w_poll_ack = rd_en & r_poll;
  assign w_rd_data  = w_poll_ack ? {int_req, 4'b0000, int_vec} : w_reg_rd;
`else
  logic w_unused_poll;

  assign w_unused_poll = int_req;
  assign w_poll_ack    = 1'b0;
  assign w_rd_data     = w_reg_rd;
`endif

  pic_inta_sequencer u_inta (
    .clk           (clk),
    .rst           (rst),
    .i_enable      (w_ready),
    .i_clr_count   (w_icw1),
    .i_inta_n      (inta_n),
    .i_int_vec     (int_vec),
    .i_vector_base (r_vector_base),
    .i_rd_req      (rd_en),
    .i_rd_data     (w_rd_data),
    .i_poll_ack    (w_poll_ack),
    .o_ack_first   (ack_first),
    .o_ack_second  (ack_second),
    .o_data_out    (data_out),
    .o_data_oe     (data_oe)
  );

  assign IM        = r_im;
  assign operation = r_operation;
  assign op_valid  = r_op_valid;
  assign LTIM      = r_ltim;
  assign AEOI      = r_aeoi;
  assign ready     = w_ready;

endmodule
